// File: rtl/i2c_byte_master.sv
// i2c_byte_master: register-mapped byte-level I2C master (START, one byte + ACK, STOP).
// Define I2C_STRETCH_EN to let the prescaler hold while a slave stretches SCL.
module i2c_byte_master #(
   parameter logic [15:0] DIV_RESET = 16'd124
) (
   input  logic        Clk,
   input  logic        ResetN,
   input  logic [2:0]  Addr,
   output logic [15:0] DataRd,
   input  logic [15:0] DataWr,
   input  logic        En,
   input  logic        Rd,
   input  logic        Wr,
   output logic        SdaOut,
   input  logic        SdaIn,
   output logic        SclOut,
   input  logic        SclIn
);

   typedef enum logic [1:0] {IDLE, START, BYTE, STOP} state_t;

   state_t      state, state_nxt;
   logic [1:0]  qtr, qtr_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [15:0] div, div_nxt;
   logic [7:0]  tx_data, tx_data_nxt;
   logic [7:0]  rx_data, rx_data_nxt;
   logic        done, done_nxt;
   logic        rx_ack, rx_ack_nxt;
   logic        arb_lost, arb_lost_nxt;
   logic        held, held_nxt;
   logic        do_byte, do_byte_nxt;
   logic        do_write, do_write_nxt;
   logic        do_sto, do_sto_nxt;
   logic        ack_out, ack_out_nxt;

   logic busy, wr_en, accept, tick, stall;
   logic ack_bit, data_bit, byte_sda;
   logic scl_pull, sda_pull, scl_high;
   logic unused_ok;

   assign busy      = (state != IDLE);
   assign wr_en     = Wr & En;
   assign accept    = wr_en & ~busy & (Addr == 3'd0) & (|DataWr[3:0]);
   assign ack_bit   = bit_cnt[3];
   assign data_bit  = tx_data[3'd7 - bit_cnt[2:0]];
   assign tick      = (cnt == div) & ~stall;
   assign unused_ok = ^{Rd, scl_high};

   // Line drive per stage/quarter; IDLE keeps SCL low while the bus is held
   always_comb begin
      scl_pull = 1'b0;
      sda_pull = 1'b0;
      scl_high = 1'b0;
      byte_sda = 1'b0;
      if (ack_bit)
         byte_sda = do_write ? 1'b0 : ~ack_out;
      else
         byte_sda = do_write & ~data_bit;
      unique case (state)
         IDLE: scl_pull = held;
         START: begin
            scl_high = (qtr != 2'd0);
            scl_pull = (qtr == 2'd0) & held;
            sda_pull = qtr[1];
         end
         BYTE: begin
            scl_high = qtr[1];
            scl_pull = ~qtr[1];
            sda_pull = byte_sda;
         end
         STOP: begin
            scl_high = (qtr != 2'd0);
            scl_pull = (qtr == 2'd0);
            sda_pull = ~qtr[1];
         end
         default: ;
      endcase
   end

   assign SdaOut = sda_pull;
   assign SclOut = scl_pull;

`ifdef I2C_STRETCH_EN
   assign stall = scl_high & ~scl_pull & ~SclIn;
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      DataRd = 16'h0000;
      unique case (Addr)
         3'd0: DataRd = {9'h000, SdaIn, SclIn, held, done,
                         arb_lost, rx_ack, busy};
         3'd1: DataRd = {8'h00, rx_data};
         3'd2: DataRd = div;
         default: ;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      qtr_nxt      = qtr;
      bit_cnt_nxt  = bit_cnt;
      div_nxt      = div;
      tx_data_nxt  = tx_data;
      rx_data_nxt  = rx_data;
      done_nxt     = done;
      rx_ack_nxt   = rx_ack;
      arb_lost_nxt = arb_lost;
      held_nxt     = held;
      do_byte_nxt  = do_byte;
      do_write_nxt = do_write;
      do_sto_nxt   = do_sto;
      ack_out_nxt  = ack_out;
      if (tick)
         cnt_nxt = 16'd0;
      else if (stall)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt + 16'd1;

      if (wr_en & ~busy) begin
         if (Addr == 3'd1) tx_data_nxt = DataWr[7:0];
         if (Addr == 3'd2) div_nxt = DataWr;
      end

      if (accept) begin
         cnt_nxt      = 16'd0;
         qtr_nxt      = 2'd0;
         bit_cnt_nxt  = 4'd0;
         done_nxt     = 1'b0;
         rx_ack_nxt   = 1'b0;
         arb_lost_nxt = 1'b0;
         do_sto_nxt   = DataWr[1];
         do_write_nxt = DataWr[3];
         do_byte_nxt  = DataWr[3] | DataWr[2];
         ack_out_nxt  = DataWr[4];
         if (DataWr[0])
            state_nxt = START;
         else if (|DataWr[3:2])
            state_nxt = BYTE;
         else
            state_nxt = STOP;
      end else if (busy & tick) begin
         qtr_nxt = qtr + 2'd1;
         unique case (state)
            START: begin
               if (qtr == 2'd3) begin
                  bit_cnt_nxt = 4'd0;
                  if (do_byte)
                     state_nxt = BYTE;
                  else if (do_sto)
                     state_nxt = STOP;
                  else begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            BYTE: begin
               // Sample point: middle of the SCL-high phase
               if (qtr == 2'd2) begin
                  if (do_write & ~ack_bit & data_bit & ~SdaIn) begin
                     arb_lost_nxt = 1'b1;
                     held_nxt     = 1'b0;
                     done_nxt     = 1'b1;
                     state_nxt    = IDLE;
                     qtr_nxt      = 2'd0;
                  end else if (ack_bit) begin
                     if (do_write) rx_ack_nxt = SdaIn;
                  end else if (~do_write) begin
                     rx_data_nxt = {rx_data[6:0], SdaIn};
                  end
               end
               if (qtr == 2'd3) begin
                  if (!ack_bit)
                     bit_cnt_nxt = bit_cnt + 4'd1;
                  else if (do_sto)
                     state_nxt = STOP;
                  else begin
                     state_nxt = IDLE;
                     held_nxt  = 1'b1;
                     done_nxt  = 1'b1;
                  end
               end
            end
            STOP: begin
               if (qtr == 2'd3) begin
                  state_nxt = IDLE;
                  held_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state    <= IDLE;
         qtr      <= 2'd0;
         bit_cnt  <= 4'd0;
         cnt      <= 16'd0;
         div      <= DIV_RESET;
         tx_data  <= 8'h00;
         rx_data  <= 8'h00;
         done     <= 1'b0;
         rx_ack   <= 1'b0;
         arb_lost <= 1'b0;
         held     <= 1'b0;
         do_byte  <= 1'b0;
         do_write <= 1'b0;
         do_sto   <= 1'b0;
         ack_out  <= 1'b0;
      end else begin
         state    <= state_nxt;
         qtr      <= qtr_nxt;
         bit_cnt  <= bit_cnt_nxt;
         cnt      <= cnt_nxt;
         div      <= div_nxt;
         tx_data  <= tx_data_nxt;
         rx_data  <= rx_data_nxt;
         done     <= done_nxt;
         rx_ack   <= rx_ack_nxt;
         arb_lost <= arb_lost_nxt;
         held     <= held_nxt;
         do_byte  <= do_byte_nxt;
         do_write <= do_write_nxt;
         do_sto   <= do_sto_nxt;
         ack_out  <= ack_out_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: register vectors, table of I2C transfers with a slave
// model and a bit scoreboard, plus an asynchronous mid-transfer reset.
module tb_i2c_byte_master;

   logic        clk;
   logic        rst_n;
   logic [2:0]  addr;
   logic [15:0] data_rd;
   logic [15:0] data_wr;
   logic        en;
   logic        rd;
   logic        wr;
   logic        sda_out;
   logic        sda_in;
   logic        scl_out;
   logic        scl_in;
   logic        sda_pull;
   logic        scl_hold;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef I2C_STRETCH_EN
   localparam int STRETCH_CYC = 108;
`else
   localparam int STRETCH_CYC = 88;
`endif

   typedef struct {
      logic        en;
      logic        wr;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [2:0]  raddr;
      logic [15:0] exp;
   } reg_vec_t;

   typedef struct {
      logic [15:0] div;
      logic [7:0]  tx;
      logic [4:0]  cmd;
      logic [8:0]  pull;
      int          nchk;
      logic [8:0]  bits;
      int          hold_idx;
      int          mw_cyc;
      int          cycles;
      logic [15:0] status;
      logic [7:0]  rx;
      logic        scl_idle;
   } xfer_t;

   typedef struct {
      int   idx;
      logic val;
   } bit_exp_t;

   bit_exp_t exp_q[$];
   reg_vec_t rv[10];
   xfer_t    xv[8];

   assign sda_in = ~(sda_out | sda_pull);
   assign scl_in = ~(scl_out | scl_hold);

   i2c_byte_master dut (
      .Clk(clk),
      .ResetN(rst_n),
      .Addr(addr),
      .DataRd(data_rd),
      .DataWr(data_wr),
      .En(en),
      .Rd(rd),
      .Wr(wr),
      .SdaOut(sda_out),
      .SdaIn(sda_in),
      .SclOut(scl_out),
      .SclIn(scl_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      en = 1'b1; wr = 1'b1; addr = a; data_wr = d;
      @(posedge clk); #1;
      en = 1'b0; wr = 1'b0; addr = 3'd0; data_wr = 16'h0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      addr = a; rd = 1'b1; en = 1'b1;
      #1 d = data_rd;
      rd = 1'b0; en = 1'b0; addr = 3'd0;
   endtask

   task automatic run_xfer(input xfer_t x, input string nm);
      bit_exp_t    e;
      logic [15:0] st, st_end, rdv;
      logic        sdo_end, sco_end, scl, sda, prev_scl, prev_sda;
      logic [3:0]  bi;
      int          idx, hold_left, cycles;
      bit          fin;
      bus_write(3'd1, {8'h00, x.tx});
      bus_write(3'd2, x.div);
      sda_pull = 1'b0;
      scl_hold = 1'b0;
      exp_q.delete();
      for (int i = 0; i < x.nchk; i++) begin
         bi = 4'(8 - i);
         exp_q.push_back('{i, x.bits[bi]});
      end
      @(posedge clk); #1;
      en = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'd0;
      data_wr = {11'h000, x.cmd};
      prev_scl = ~scl_out;
      prev_sda = ~sda_out;
      idx = -1; hold_left = 0; cycles = 0; fin = 1'b0;
      st_end = 16'h0; sdo_end = 1'b0; sco_end = 1'b0;
      for (int c = 0; c < 4000 && !fin; c++) begin
         @(posedge clk); #1;
         wr = 1'b0; addr = 3'd0; data_wr = 16'h0;
         #1 st = data_rd;
         if (st[0]) cycles++;
         else begin
            fin = 1'b1;
            st_end = st; sdo_end = sda_out; sco_end = scl_out;
         end
         if (!fin) begin
            scl = ~scl_out;
            sda = ~sda_out;
            if (hold_left > 0) begin
               hold_left--;
               if (hold_left == 0) scl_hold = 1'b0;
            end
            if (prev_scl && scl && prev_sda && !sda) idx = -1;
            if (!prev_scl && scl && idx >= 0 && idx <= 8) begin
               if (exp_q.size() > 0 && exp_q[0].idx == idx) begin
                  e = exp_q.pop_front();
                  check($sformatf("%s bit%0d", nm, idx),
                        16'(sda_in), 16'(e.val));
               end
               if (idx == x.hold_idx) begin
                  scl_hold = 1'b1;
                  hold_left = 20;
               end
            end
            if (prev_scl && !scl) begin
               idx++;
               bi = 4'(8 - idx);
               sda_pull = (idx >= 0 && idx <= 8) ? x.pull[bi] : 1'b0;
            end
            prev_scl = scl;
            prev_sda = sda;
            if (c == x.mw_cyc) begin
               wr = 1'b1; addr = 3'd2; data_wr = 16'h0005;
            end
            if (x.mw_cyc >= 0 && c == x.mw_cyc + 2) begin
               wr = 1'b1; addr = 3'd0; data_wr = 16'h0008;
            end
         end
      end
      if (!fin) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: busy still 1, expected 0", nm);
      end else begin
         check({nm, " busy cycles"}, 16'(cycles), 16'(x.cycles));
         check({nm, " status"}, st_end, x.status);
         check({nm, " sda_out end"}, 16'(sdo_end), 16'h0);
         check({nm, " scl_out end"}, 16'(sco_end), 16'(x.scl_idle));
      end
      check({nm, " pending bits"}, 16'(exp_q.size()), 16'h0);
      sda_pull = 1'b0;
      scl_hold = 1'b0;
      en = 1'b0; rd = 1'b0; wr = 1'b0;
      repeat (5) @(posedge clk);
      #1 check({nm, " idle scl_out"}, 16'(scl_out), 16'(x.scl_idle));
      bus_read(3'd1, rdv);
      check({nm, " rx_data"}, rdv, {8'h00, x.rx});
      bus_read(3'd2, rdv);
      check({nm, " div"}, rdv, x.div);
   endtask

   initial begin
      logic [15:0] rdv;
      rst_n = 1'b0;
      en = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = 3'd0; data_wr = 16'h0;
      sda_pull = 1'b0; scl_hold = 1'b0;

      rv[0] = '{1'b1, 1'b1, 3'd2, 16'h0001, 3'd2, 16'h0001};
      rv[1] = '{1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, 16'h0001};
      rv[2] = '{1'b1, 1'b0, 3'd2, 16'h4321, 3'd2, 16'h0001};
      rv[3] = '{1'b1, 1'b1, 3'd1, 16'h00A5, 3'd1, 16'h0000};
      rv[4] = '{1'b1, 1'b1, 3'd0, 16'h0010, 3'd0, 16'h0060};
      rv[5] = '{1'b1, 1'b1, 3'd0, 16'h0000, 3'd0, 16'h0060};
      rv[6] = '{1'b1, 1'b1, 3'd3, 16'hFFFF, 3'd3, 16'h0000};
      rv[7] = '{1'b1, 1'b1, 3'd7, 16'hFFFF, 3'd7, 16'h0000};
      rv[8] = '{1'b1, 1'b1, 3'd2, 16'hBEEF, 3'd2, 16'hBEEF};
      rv[9] = '{1'b1, 1'b1, 3'd2, 16'h0001, 3'd2, 16'h0001};

      xv[0] = '{16'd1, 8'hA5, 5'h0B, 9'b000000001, 9, 9'b101001010,
                -1, -1, 88, 16'h0068, 8'h00, 1'b0};
      xv[1] = '{16'd0, 8'h00, 5'h15, 9'b110000110, 9, 9'b001111001,
                -1, -1, 40, 16'h0058, 8'h3C, 1'b1};
      xv[2] = '{16'd0, 8'hFF, 5'h0B, 9'b010000000, 1, 9'b100000000,
                -1, -1, 11, 16'h002C, 8'h3C, 1'b0};
      xv[3] = '{16'd1, 8'h5A, 5'h0B, 9'b000000001, 9, 9'b010110100,
                -1, 10, 88, 16'h0068, 8'h3C, 1'b0};
      xv[4] = '{16'd1, 8'hC3, 5'h0B, 9'b000000001, 9, 9'b110000110,
                3, -1, STRETCH_CYC, 16'h0068, 8'h3C, 1'b0};
      xv[5] = '{16'd0, 8'h81, 5'h09, 9'b000000000, 9, 9'b100000011,
                -1, -1, 40, 16'h005A, 8'h3C, 1'b1};
      xv[6] = '{16'd0, 8'h00, 5'h02, 9'b000000000, 0, 9'b000000000,
                -1, -1, 4, 16'h0068, 8'h3C, 1'b0};
      xv[7] = '{16'd0, 8'h0F, 5'h0F, 9'b000000001, 9, 9'b000011110,
                -1, -1, 44, 16'h0068, 8'h3C, 1'b0};

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset sda_out", 16'(sda_out), 16'h0);
      check("reset scl_out", 16'(scl_out), 16'h0);
      bus_read(3'd0, rdv);
      check("reset status", rdv, 16'h0060);
      bus_read(3'd2, rdv);
      check("reset div", rdv, 16'd124);

      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         en = rv[i].en; wr = rv[i].wr;
         addr = rv[i].addr; data_wr = rv[i].data;
         @(posedge clk); #1;
         en = 1'b0; wr = 1'b0; data_wr = 16'h0;
         bus_read(rv[i].raddr, rdv);
         check($sformatf("regvec%0d", i), rdv, rv[i].exp);
      end

      for (int i = 0; i < 8; i++)
         run_xfer(xv[i], $sformatf("xfer%0d", i));

      // Asynchronous reset in the middle of a byte
      bus_write(3'd1, 16'h0000);
      bus_write(3'd2, 16'h0001);
      bus_write(3'd0, 16'h000B);
      repeat (30) @(posedge clk);
      #1 check("mid-xfer line active", 16'(sda_out | scl_out), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset sda_out", 16'(sda_out), 16'h0);
      check("async reset scl_out", 16'(scl_out), 16'h0);
      bus_read(3'd0, rdv);
      check("async reset status", rdv, 16'h0060);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_read(3'd2, rdv);
      check("async reset div", rdv, 16'd124);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
